// File: rtl/axil_decode_bus.sv
// AXI4-Lite 1-to-NUM_M address-decoding bus with independent read/write paths.
// Optional watchdog on stalled downstream ports: define AXIL_BUS_TIMEOUT_EN.
module axil_decode_bus #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned RESP_WIDTH     = 2,
  parameter int unsigned NUM_M          = 2,
  parameter int unsigned REGION_BITS    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                           s0_axi_aclk,
  input  logic                           s0_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]          s0_axi_awaddr,
  input  logic                           s0_axi_awvalid,
  output logic                           s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s0_axi_wstrb,
  input  logic                           s0_axi_wvalid,
  output logic                           s0_axi_wready,
  output logic [RESP_WIDTH-1:0]          s0_axi_bresp,
  output logic                           s0_axi_bvalid,
  input  logic                           s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s0_axi_araddr,
  input  logic                           s0_axi_arvalid,
  output logic                           s0_axi_arready,
  output logic [DATA_WIDTH-1:0]          s0_axi_rdata,
  output logic [RESP_WIDTH-1:0]          s0_axi_rresp,
  output logic                           s0_axi_rvalid,
  input  logic                           s0_axi_rready,
  output logic [NUM_M*ADDR_WIDTH-1:0]    m_axi_awaddr,
  output logic [NUM_M-1:0]               m_axi_awvalid,
  input  logic [NUM_M-1:0]               m_axi_awready,
  output logic [NUM_M*DATA_WIDTH-1:0]    m_axi_wdata,
  output logic [NUM_M*DATA_WIDTH/8-1:0]  m_axi_wstrb,
  output logic [NUM_M-1:0]               m_axi_wvalid,
  input  logic [NUM_M-1:0]               m_axi_wready,
  input  logic [NUM_M*RESP_WIDTH-1:0]    m_axi_bresp,
  input  logic [NUM_M-1:0]               m_axi_bvalid,
  output logic [NUM_M-1:0]               m_axi_bready,
  output logic [NUM_M*ADDR_WIDTH-1:0]    m_axi_araddr,
  output logic [NUM_M-1:0]               m_axi_arvalid,
  input  logic [NUM_M-1:0]               m_axi_arready,
  input  logic [NUM_M*DATA_WIDTH-1:0]    m_axi_rdata,
  input  logic [NUM_M*RESP_WIDTH-1:0]    m_axi_rresp,
  input  logic [NUM_M-1:0]               m_axi_rvalid,
  output logic [NUM_M-1:0]               m_axi_rready
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam logic [RESP_WIDTH-1:0] RespSlvErr = RESP_WIDTH'(2);
  localparam logic [RESP_WIDTH-1:0] RespDecErr = RESP_WIDTH'(3);

  typedef enum logic [1:0] {StWIdle, StWFwd, StWWait, StWResp} w_state_e;
  typedef enum logic [1:0] {StRIdle, StRFwd, StRWait, StRResp} r_state_e;

  function automatic logic is_mapped(input logic [ADDR_WIDTH-1:0] a);
    return int'(a[ADDR_WIDTH-1:REGION_BITS]) < int'(NUM_M);
  endfunction

  function automatic logic [NUM_M-1:0] port_sel(input logic [ADDR_WIDTH-1:0] a);
    logic [NUM_M-1:0] s;
    s = '0;
    for (int k = 0; k < int'(NUM_M); k++) s[k] = (int'(a[ADDR_WIDTH-1:REGION_BITS]) == k);
    return s;
  endfunction

  w_state_e                wstate_q, wstate_d;
  logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                    awready_q, awready_d, wready_q, wready_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [StrbW-1:0]        wstrb_q, wstrb_d;
  logic [NUM_M-1:0]        m_awvalid_q, m_awvalid_d, m_wvalid_q, m_wvalid_d;
  logic [NUM_M-1:0]        m_bready_q, m_bready_d, w_sel;
  logic                    bvalid_q, bvalid_d;
  logic [RESP_WIDTH-1:0]   bresp_q, bresp_d, m_bresp_sel;

  r_state_e                rstate_q, rstate_d;
  logic                    arready_q, arready_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [NUM_M-1:0]        m_arvalid_q, m_arvalid_d, m_rready_q, m_rready_d, r_sel;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d, m_rdata_sel;
  logic [RESP_WIDTH-1:0]   rresp_q, rresp_d, m_rresp_sel;

`ifdef AXIL_BUS_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
`endif

  assign w_sel = port_sel(awaddr_q);
  assign r_sel = port_sel(araddr_q);

  // Response muxes driven by the latched address of each path.
  always_comb begin
    m_bresp_sel = '0;
    m_rresp_sel = '0;
    m_rdata_sel = '0;
    for (int k = 0; k < int'(NUM_M); k++) begin
      if (w_sel[k]) m_bresp_sel = m_axi_bresp[k*RESP_WIDTH +: RESP_WIDTH];
      if (r_sel[k]) begin
        m_rresp_sel = m_axi_rresp[k*RESP_WIDTH +: RESP_WIDTH];
        m_rdata_sel = m_axi_rdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    wstate_d    = wstate_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    m_awvalid_d = m_awvalid_q;
    m_wvalid_d  = m_wvalid_q;
    m_bready_d  = m_bready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
`ifdef AXIL_BUS_TIMEOUT_EN
    w_cnt_d     = '0;
`endif
    unique case (wstate_q)
      StWIdle: begin
        if (awready_q && s0_axi_awvalid) begin
          aw_done_d = 1'b1;
          awaddr_d  = s0_axi_awaddr;
        end
        if (wready_q && s0_axi_wvalid) begin
          w_done_d = 1'b1;
          wdata_d  = s0_axi_wdata;
          wstrb_d  = s0_axi_wstrb;
        end
        if (aw_done_d && w_done_d) begin
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          m_bready_d = '0;
          if (is_mapped(awaddr_d)) begin
            wstate_d    = StWFwd;
            m_awvalid_d = port_sel(awaddr_d);
            m_wvalid_d  = port_sel(awaddr_d);
          end else begin
            wstate_d = StWResp;
            bvalid_d = 1'b1;
            bresp_d  = RespDecErr;
          end
        end
      end
      StWFwd: begin
        m_awvalid_d = m_awvalid_q & ~m_axi_awready;
        m_wvalid_d  = m_wvalid_q & ~m_axi_wready;
        if (m_awvalid_d == '0 && m_wvalid_d == '0) begin
          wstate_d   = StWWait;
          m_bready_d = w_sel;
        end
      end
      StWWait: begin
        if (|(m_bready_q & m_axi_bvalid)) begin
          bresp_d    = m_bresp_sel;
          m_bready_d = '0;
          bvalid_d   = 1'b1;
          wstate_d   = StWResp;
        end
      end
      StWResp: begin
        if (s0_axi_bready) begin
          bvalid_d = 1'b0;
          wstate_d = StWIdle;
        end
      end
      default: wstate_d = StWIdle;
    endcase
`ifdef AXIL_BUS_TIMEOUT_EN
    if (wstate_q == StWFwd || wstate_q == StWWait) begin
      w_cnt_d = w_cnt_q + 1'b1;
      if (w_cnt_d == CntW'(TIMEOUT_CYCLES) && wstate_d != StWResp) begin
        m_awvalid_d = '0;
        m_wvalid_d  = '0;
        m_bready_d  = '0;
        bvalid_d    = 1'b1;
        bresp_d     = RespSlvErr;
        wstate_d    = StWResp;
        w_cnt_d     = '0;
      end
    end
    // Idle absorbs late responses from abandoned transactions.
    if (wstate_d == StWIdle) m_bready_d = '1;
`endif
    awready_d = (wstate_d == StWIdle) && !aw_done_d;
    wready_d  = (wstate_d == StWIdle) && !w_done_d;
  end

  always_comb begin
    rstate_d    = rstate_q;
    araddr_d    = araddr_q;
    m_arvalid_d = m_arvalid_q;
    m_rready_d  = m_rready_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
`ifdef AXIL_BUS_TIMEOUT_EN
    r_cnt_d     = '0;
`endif
    unique case (rstate_q)
      StRIdle: begin
        if (arready_q && s0_axi_arvalid) begin
          araddr_d   = s0_axi_araddr;
          m_rready_d = '0;
          if (is_mapped(s0_axi_araddr)) begin
            rstate_d    = StRFwd;
            m_arvalid_d = port_sel(s0_axi_araddr);
          end else begin
            rstate_d = StRResp;
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RespDecErr;
          end
        end
      end
      StRFwd: begin
        m_arvalid_d = m_arvalid_q & ~m_axi_arready;
        if (m_arvalid_d == '0) begin
          rstate_d   = StRWait;
          m_rready_d = r_sel;
        end
      end
      StRWait: begin
        if (|(m_rready_q & m_axi_rvalid)) begin
          rdata_d    = m_rdata_sel;
          rresp_d    = m_rresp_sel;
          m_rready_d = '0;
          rvalid_d   = 1'b1;
          rstate_d   = StRResp;
        end
      end
      StRResp: begin
        if (s0_axi_rready) begin
          rvalid_d = 1'b0;
          rstate_d = StRIdle;
        end
      end
      default: rstate_d = StRIdle;
    endcase
`ifdef AXIL_BUS_TIMEOUT_EN
    if (rstate_q == StRFwd || rstate_q == StRWait) begin
      r_cnt_d = r_cnt_q + 1'b1;
      if (r_cnt_d == CntW'(TIMEOUT_CYCLES) && rstate_d != StRResp) begin
        m_arvalid_d = '0;
        m_rready_d  = '0;
        rvalid_d    = 1'b1;
        rdata_d     = '0;
        rresp_d     = RespSlvErr;
        rstate_d    = StRResp;
        r_cnt_d     = '0;
      end
    end
    if (rstate_d == StRIdle) m_rready_d = '1;
`endif
    arready_d = (rstate_d == StRIdle);
  end

  always_ff @(posedge s0_axi_aclk) begin
    if (!s0_axi_aresetn) begin
      wstate_q    <= StWIdle;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      m_awvalid_q <= '0;
      m_wvalid_q  <= '0;
      m_bready_q  <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= '0;
`ifdef AXIL_BUS_TIMEOUT_EN
      w_cnt_q     <= '0;
`endif
    end else begin
      wstate_q    <= wstate_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      m_awvalid_q <= m_awvalid_d;
      m_wvalid_q  <= m_wvalid_d;
      m_bready_q  <= m_bready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
`ifdef AXIL_BUS_TIMEOUT_EN
      w_cnt_q     <= w_cnt_d;
`endif
    end
  end

  always_ff @(posedge s0_axi_aclk) begin
    if (!s0_axi_aresetn) begin
      rstate_q    <= StRIdle;
      arready_q   <= 1'b0;
      araddr_q    <= '0;
      m_arvalid_q <= '0;
      m_rready_q  <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= '0;
`ifdef AXIL_BUS_TIMEOUT_EN
      r_cnt_q     <= '0;
`endif
    end else begin
      rstate_q    <= rstate_d;
      arready_q   <= arready_d;
      araddr_q    <= araddr_d;
      m_arvalid_q <= m_arvalid_d;
      m_rready_q  <= m_rready_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
`ifdef AXIL_BUS_TIMEOUT_EN
      r_cnt_q     <= r_cnt_d;
`endif
    end
  end

  assign s0_axi_awready = awready_q;
  assign s0_axi_wready  = wready_q;
  assign s0_axi_bvalid  = bvalid_q;
  assign s0_axi_bresp   = bresp_q;
  assign s0_axi_arready = arready_q;
  assign s0_axi_rvalid  = rvalid_q;
  assign s0_axi_rdata   = rdata_q;
  assign s0_axi_rresp   = rresp_q;

  // Address and data are broadcast; only the selected port sees a valid.
  assign m_axi_awaddr  = {NUM_M{awaddr_q}};
  assign m_axi_wdata   = {NUM_M{wdata_q}};
  assign m_axi_wstrb   = {NUM_M{wstrb_q}};
  assign m_axi_araddr  = {NUM_M{araddr_q}};
  assign m_axi_awvalid = m_awvalid_q;
  assign m_axi_wvalid  = m_wvalid_q;
  assign m_axi_bready  = m_bready_q;
  assign m_axi_arvalid = m_arvalid_q;
  assign m_axi_rready  = m_rready_q;

endmodule
